mem_arbiter: RTL and testbench

Two-port arbiter that shares the single unified memory (instruction, data and peripheral map) between two requesters. Port 0 is the multi-cycle core; port 1 is a loader/DMA engine. Uses a req/ack handshake with round-robin arbitration, optional locked bursts with a length cap, and misaligned-word rejection. Sits between the requesters and the memory's A/WD/WE/RD port.

---
 rtl/mem_arbiter_if.sv | 27 ++
 rtl/mem_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Requester-side bus of the memory arbiter: req/ack handshake with
// optional burst lock, byte address, write data and registered read data.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              req;
  logic              lock;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic              err;
  logic [DATA_W-1:0] rdata;

  // Requester drives the command, arbiter returns the completion
  modport master (
    output req, lock, we, addr, wdata,
    input  ack, err, rdata
  );

  // Arbiter view of a requester
  modport slave (
    input  req, lock, we, addr, wdata,
    output ack, err, rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported unified memory.
// Each transaction takes ACCESS (memory cycle) then RESP (ack pulse); a port
// holding lock may keep the grant for up to MAX_BURST consecutive accesses.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_BURST   = 4,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_arbiter_if.slave      m0,
  mem_arbiter_if.slave      m1,
  output logic [ADDR_W-1:0] mem_A,
  output logic [DATA_W-1:0] mem_WD,
  output logic              mem_WE,
  input  logic [DATA_W-1:0] mem_RD,
  output logic              busy,
  output logic              grant_id
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Both requesters flattened into index-able vectors so the granted port
  // can be selected with gnt_q directly
  logic [1:0]             req_in;
  logic [1:0]             lock_in;
  logic [1:0]             we_in;
  logic [1:0][ADDR_W-1:0] addr_in;
  logic [1:0][DATA_W-1:0] wdata_in;
  logic [1:0]             ack_out;
  logic [1:0]             err_out;
  logic [1:0][DATA_W-1:0] rdata_out;

  assign req_in   = {m1.req,   m0.req};
  assign lock_in  = {m1.lock,  m0.lock};
  assign we_in    = {m1.we,    m0.we};
  assign addr_in  = {m1.addr,  m0.addr};
  assign wdata_in = {m1.wdata, m0.wdata};

  assign m0.ack   = ack_out[0];
  assign m0.err   = err_out[0];
  assign m0.rdata = rdata_out[0];
  assign m1.ack   = ack_out[1];
  assign m1.err   = err_out[1];
  assign m1.rdata = rdata_out[1];

  state_t           state_q, state_d;
  logic             gnt_q, gnt_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             err_q, err_d;

  logic              in_access;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_misalign;
  logic              burst_continue;

  // Round-robin pick: a lone requester wins, a tie goes to the port that
  // was not granted last
  function automatic logic rr_pick(input logic [1:0] r, input logic last);
    logic pick;
    if (r[0] && r[1]) begin
      pick = ~last;
    end else if (r[1]) begin
      pick = 1'b1;
    end else begin
      pick = 1'b0;
    end
    return pick;
  endfunction

  assign in_access    = (state_q == ST_ACCESS);
  assign sel_we       = we_in[gnt_q];
  assign sel_addr     = addr_in[gnt_q];
  assign sel_wdata    = wdata_in[gnt_q];
  assign sel_misalign = CHECK_ALIGN && (sel_addr[1:0] != 2'b00);

  // The locked port keeps the bus while it still asks and has burst budget left
  assign burst_continue = lock_in[gnt_q] && req_in[gnt_q] && (burst_cnt_q < MAX_CNT);

  // Next state, grant and burst count
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    burst_cnt_d = burst_cnt_q;
    err_d       = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_in != 2'b00) begin
          gnt_d       = rr_pick(req_in, gnt_q);
          burst_cnt_d = CNT_ONE;
          state_d     = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // The error flag belongs to this access and is shown with its ack
        err_d   = sel_misalign;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (burst_continue) begin
          burst_cnt_d = burst_cnt_q + CNT_ONE;
          state_d     = ST_ACCESS;
        end else if (req_in != 2'b00) begin
          // Cap reached or no lock: normal arbitration, which re-grants the
          // same port with a fresh count when the other one is quiet
          gnt_d       = rr_pick(req_in, gnt_q);
          burst_cnt_d = CNT_ONE;
          state_d     = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control registers; grant resets to port 1 so port 0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= 1'b1;
      burst_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      burst_cnt_q <= burst_cnt_d;
      err_q       <= err_d;
    end
  end

  // Memory port decode: only an aligned access in ACCESS reaches memory,
  // and an async reset drops mem_WE at once because state_q leaves ACCESS
  always_comb begin
    mem_A  = '0;
    mem_WD = '0;
    mem_WE = 1'b0;
    if (in_access && !sel_misalign) begin
      mem_A  = sel_addr;
      mem_WD = sel_wdata;
      mem_WE = sel_we;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic [DATA_W-1:0] rdata_q, rdata_d;

    // Capture memory data only for this port's own aligned read
    always_comb begin
      rdata_d = rdata_q;
      if (in_access && (gnt_q == 1'(gi)) && !sel_we && !sel_misalign) begin
        rdata_d = mem_RD;
      end
    end

    // Read data holds between acks
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_q <= '0;
      end else begin
        rdata_q <= rdata_d;
      end
    end

    assign rdata_out[gi] = rdata_q;
    assign ack_out[gi]   = (state_q == ST_RESP) && (gnt_q == 1'(gi));
    assign err_out[gi]   = ack_out[gi] && err_q;
  end

  assign busy     = (state_q != ST_IDLE);
  assign grant_id = gnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model predicts the
// service order and responses; a negedge monitor checks every ack.
module tb_mem_arbiter;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 4;
  localparam int MEM_WORDS = 256;

  typedef struct {
    bit          we;
    bit          lock;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    int          port;
    bit          we;
    logic [31:0] addr;
    bit          err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();

  logic [ADDR_W-1:0] mem_A;
  logic [DATA_W-1:0] mem_WD;
  logic              mem_WE;
  logic [DATA_W-1:0] mem_RD;
  logic              busy;
  logic              grant_id;

  mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .CHECK_ALIGN(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .m0(m0_if), .m1(m1_if),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD),
    .busy(busy), .grant_id(grant_id)
  );

  // Requester drive
  logic [1:0]       req_t = '0, lock_t = '0, we_t = '0;
  logic [1:0][31:0] addr_t = '0, wdata_t = '0;
  logic [1:0]       ack_t;

  assign m0_if.req = req_t[0];   assign m1_if.req = req_t[1];
  assign m0_if.lock = lock_t[0]; assign m1_if.lock = lock_t[1];
  assign m0_if.we = we_t[0];     assign m1_if.we = we_t[1];
  assign m0_if.addr = addr_t[0]; assign m1_if.addr = addr_t[1];
  assign m0_if.wdata = wdata_t[0]; assign m1_if.wdata = wdata_t[1];
  assign ack_t = {m1_if.ack, m0_if.ack};

  // Memory attached to the DUT's memory port
  logic [31:0] mem [MEM_WORDS];
  assign mem_RD = mem[mem_A[9:2]];
  always @(posedge clk) if (mem_WE) mem[mem_A[9:2]] <= mem_WD;

  // Reference state
  logic [31:0] ref_mem [MEM_WORDS];
  logic [31:0] ref_rdata [2];
  int          model_gid;
  txn_t        drv_q0[$], drv_q1[$];
  exp_t        sb[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int we_cycles = 0;

  always @(posedge clk) begin
    cyc++;
    if (mem_WE) we_cycles++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ack is matched against the next predicted response
  exp_t mon_e;
  int   mon_p;
  always @(negedge clk) begin
    if (rst_n && (ack_t != 2'b00)) begin
      chk("single_ack", ack_t == 2'b11, 1'b0);
      chk("ack_expected", sb.size() > 0, 1'b1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        mon_p = ack_t[1] ? 1 : 0;
        chk("ack_port", mon_p, mon_e.port);
        chk("grant_id", grant_id, mon_e.port[0]);
        chk("ack_cycle", cyc, mon_e.cyc);
        chk("err", mon_p ? m1_if.err : m0_if.err, mon_e.err);
        chk("rdata", mon_p ? m1_if.rdata : m0_if.rdata, mon_e.rdata);
        $display("TXN port=%0d we=%0d addr=0x%08h err=%0d rdata=0x%08h cyc=%0d",
                 mon_p, mon_e.we, mon_e.addr, mon_e.err, mon_e.rdata, cyc);
      end
    end
  end

  // Reference model: walks the queued work of both ports in service order
  // using the arbitration rules (round robin, lock with burst cap) and
  // predicts each response; both ports request back-to-back, so the i-th
  // ack lands 2*(i+1) cycles after the start.
  task automatic model_scenario(input int start);
    txn_t a[$], b[$];
    txn_t t;
    exp_t e;
    int   g, cnt, n;
    bit   first, has0, has1, cont;
    a = drv_q0; b = drv_q1;
    first = 1'b1; cnt = 0; n = 0; g = 0;
    while (a.size() > 0 || b.size() > 0) begin
      has0 = a.size() > 0;
      has1 = b.size() > 0;
      cont = 1'b0;
      if (!first && cnt < MAX_BURST) begin
        if (model_gid == 0 && has0 && a[0].lock) cont = 1'b1;
        if (model_gid == 1 && has1 && b[0].lock) cont = 1'b1;
      end
      if (cont) begin
        g = model_gid;
        cnt++;
      end else begin
        if (has0 && has1) g = (model_gid == 0) ? 1 : 0;
        else g = has1 ? 1 : 0;
        cnt = 1;
      end
      t = (g == 1) ? b.pop_front() : a.pop_front();
      e.port = g; e.we = t.we; e.addr = t.addr; e.cyc = start + 2 * (n + 1);
      if (t.addr[1:0] != 2'b00) begin
        e.err = 1'b1;
      end else begin
        e.err = 1'b0;
        if (t.we) ref_mem[t.addr[9:2]] = t.wdata;
        else ref_rdata[g] = ref_mem[t.addr[9:2]];
      end
      e.rdata = ref_rdata[g];
      sb.push_back(e);
      model_gid = g;
      first = 1'b0;
      n++;
    end
  endtask

  task automatic present(input int p);
    txn_t t;
    if (p == 0 ? drv_q0.size() > 0 : drv_q1.size() > 0) begin
      t = (p == 0) ? drv_q0[0] : drv_q1[0];
      req_t[p] = 1'b1; lock_t[p] = t.lock; we_t[p] = t.we;
      addr_t[p] = t.addr; wdata_t[p] = t.wdata;
    end else begin
      req_t[p] = 1'b0; lock_t[p] = 1'b0;
    end
  endtask

  task automatic push_txn(input int p, input bit we, input bit lock,
                          input logic [31:0] addr, input logic [31:0] wdata);
    txn_t t;
    t.we = we; t.lock = lock; t.addr = addr; t.wdata = wdata;
    if (p == 0) drv_q0.push_back(t);
    else drv_q1.push_back(t);
  endtask

  // Runs whatever is queued on both ports, starting them together
  task automatic run_scenario();
    int start, budget, waited, mism;
    @(negedge clk);
    start = cyc;
    budget = 4 * (drv_q0.size() + drv_q1.size()) + 20;
    model_scenario(start);
    present(0);
    present(1);
    waited = 0;
    while ((drv_q0.size() > 0 || drv_q1.size() > 0) && waited < budget) begin
      @(negedge clk);
      waited++;
      if (ack_t[0] && drv_q0.size() > 0) begin void'(drv_q0.pop_front()); present(0); end
      if (ack_t[1] && drv_q1.size() > 0) begin void'(drv_q1.pop_front()); present(1); end
    end
    chk("scenario_in_budget", waited < budget, 1'b1);
    drv_q0.delete(); drv_q1.delete();
    req_t = '0; lock_t = '0;
    repeat (2) @(negedge clk);
    chk("all_acks_seen", sb.size(), 0);
    sb.delete();
    mism = 0;
    for (int i = 0; i < MEM_WORDS; i++) if (mem[i] !== ref_mem[i]) mism++;
    chk("mem_image", mism, 0);
  endtask

  initial begin
    int wbefore;
    int n0, n1;
    logic [31:0] a;

    for (int i = 0; i < MEM_WORDS; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[32'h200 >> 2] = 32'hDEADBEEF;
    ref_mem[32'h200 >> 2] = 32'hDEADBEEF;
    ref_rdata[0] = '0; ref_rdata[1] = '0;
    model_gid = 1;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ack", ack_t, 2'b00);
    chk("rst_err", {m1_if.err, m0_if.err}, 2'b00);
    chk("rst_rdata0", m0_if.rdata, 0);
    chk("rst_rdata1", m1_if.rdata, 0);
    chk("rst_mem_A", mem_A, 0);
    chk("rst_mem_WD", mem_WD, 0);
    chk("rst_mem_WE", mem_WE, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Simultaneous requests after reset: port 0 first, then port 1's write
    push_txn(0, 1'b0, 1'b0, 32'h0, 32'h0);
    push_txn(1, 1'b1, 1'b0, 32'h204, 32'h12345678);
    run_scenario();
    push_txn(0, 1'b0, 1'b0, 32'h204, 32'h0);
    run_scenario();

    // Single read of a preloaded word
    push_txn(0, 1'b0, 1'b0, 32'h200, 32'h0);
    run_scenario();

    // Fairness: both ports busy for 4 transactions each, no lock
    for (int i = 0; i < 4; i++) begin
      push_txn(0, i[0], 1'b0, 32'h100 + 32'(i * 4), $urandom);
      push_txn(1, ~i[0], 1'b0, 32'h180 + 32'(i * 4), $urandom);
    end
    run_scenario();

    // Locked burst longer than the cap with the other port waiting
    for (int i = 0; i < 6; i++) push_txn(1, 1'b0, 1'b1, 32'h40 + 32'(i * 4), 32'h0);
    push_txn(0, 1'b0, 1'b0, 32'h80, 32'h0);
    run_scenario();

    // Locked burst with the other port idle: re-granted past the cap
    for (int i = 0; i < 6; i++) push_txn(0, 1'b1, 1'b1, 32'h60 + 32'(i * 4), $urandom);
    run_scenario();

    // Misaligned write: no memory write cycle, error with ack
    wbefore = we_cycles;
    push_txn(0, 1'b1, 1'b0, 32'h202, 32'hFFFFFFFF);
    run_scenario();
    chk("misaligned_no_write", we_cycles - wbefore, 0);

    // Reset in the middle of a write access
    @(negedge clk);
    req_t[0] = 1'b1; lock_t[0] = 1'b0; we_t[0] = 1'b1;
    addr_t[0] = 32'h208; wdata_t[0] = 32'hA5A5A5A5;
    for (int i = 0; i < 6 && !mem_WE; i++) @(negedge clk);
    chk("rstmid_access_seen", mem_WE, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_mem_WE", mem_WE, 1'b0);
    chk("rstmid_mem_A", mem_A, 0);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_grant_id", grant_id, 1'b1);
    chk("rstmid_rdata0", m0_if.rdata, 0);
    chk("rstmid_rdata1", m1_if.rdata, 0);
    req_t = '0;
    @(posedge clk);
    #1 chk("rstmid_word_kept", mem[32'h208 >> 2], ref_mem[32'h208 >> 2]);
    @(negedge clk);
    rst_n = 1'b1;
    model_gid = 1;
    ref_rdata[0] = '0; ref_rdata[1] = '0;

    // First tie after reset goes to port 0
    push_txn(0, 1'b0, 1'b0, 32'h208, 32'h0);
    push_txn(1, 1'b0, 1'b0, 32'h20C, 32'h0);
    run_scenario();

    // Randomized mixes of reads, writes, locks and misaligned addresses
    for (int s = 0; s < 40; s++) begin
      n0 = $urandom_range(0, 6);
      n1 = $urandom_range(0, 6);
      for (int p = 0; p < 2; p++) begin
        for (int i = 0; i < ((p == 0) ? n0 : n1); i++) begin
          a = {22'd0, 8'($urandom_range(0, MEM_WORDS - 1)), 2'b00};
          if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
          push_txn(p, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), a, $urandom);
        end
      end
      run_scenario();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so a stuck DUT still ends the run
  initial begin
    #2000000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
